// File: rtl/instr_mem_sync.sv
// instr_mem_sync
// Synchronously-read instruction memory with a registered fetch port, a
// runtime programming port and an automatic clear-to-NOP sweep after reset.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   fetch_req    fetch request
//   fetch_addr   byte address to fetch
//   fetch_stall  core stall, holds the fetch output registers
//   fetch_ready  high while fetches can be accepted (RUN)
//   fetch_valid  fetch_instr/fetch_fault carry an accepted request's result
//   fetch_instr  fetched word (NOP_WORD on any fault)
//   fetch_fault  bit0 misaligned, bit1 out of range
//   prog_en      request programming mode
//   prog_we      write strobe while programming
//   prog_addr    byte address to write
//   prog_data    word to write
//   prog_err     one-cycle pulse after a rejected write
//   busy         high while clearing or programming
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_CLEAR | sweeping NOP_WORD through every word, one per cycle
// S_RUN   | accepting fetches
// S_PROG  | loader owns the array, fetches ignored

module instr_mem_sync #(
  parameter int                 ADDR_W         = 32,
  parameter int                 DATA_W         = 32,
  parameter int                 DEPTH          = 256,
  parameter logic [DATA_W-1:0]  NOP_WORD       = 32'h00000013,
  parameter int                 CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [1:0]        fetch_fault,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_PROG} state_t;

  state_t state, state_nx;
  logic [IDX_W-1:0] cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  // Only the index bits address the array; every bit above them feeds the
  // range check so out-of-range addresses never alias onto real words.
  logic [IDX_W-1:0] fetch_idx, prog_idx;
  logic fetch_mis, fetch_oor, prog_mis, prog_oor;
  logic accept, prog_wr, prog_ok;

  assign fetch_idx = fetch_addr[IDX_W+1:2];
  assign fetch_mis = |fetch_addr[1:0];
  assign fetch_oor = |fetch_addr[ADDR_W-1:IDX_W+2];
  assign prog_idx  = prog_addr[IDX_W+1:2];
  assign prog_mis  = |prog_addr[1:0];
  assign prog_oor  = |prog_addr[ADDR_W-1:IDX_W+2];

  // A pending PROG transition (prog_en with no stall) blocks acceptance.
  assign accept  = (state == S_RUN) && fetch_req && !fetch_stall && !prog_en;
  assign prog_wr = (state == S_PROG) && prog_we;
  assign prog_ok = !prog_mis && !prog_oor;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    fetch_ready = 1'b0;
    case (state)
      S_CLEAR: begin
        busy = 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) state_nx = S_RUN;
      end
      S_RUN: begin
        fetch_ready = 1'b1;
        if (prog_en && !fetch_stall) state_nx = S_PROG;
      end
      S_PROG: begin
        busy = 1'b1;
        if (!prog_en) state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  // Array has no reset; writes are suppressed during a reset cycle so a
  // reset mid-sweep does not touch the word under the counter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_CLEAR)
        mem[cnt] <= NOP_WORD;
      else if (prog_wr && prog_ok)
        mem[prog_idx] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_instr <= NOP_WORD;
      fetch_fault <= 2'b00;
      prog_err    <= 1'b0;
    end else begin
      prog_err <= prog_wr && !prog_ok;
      case (state)
        S_RUN: begin
          if (!fetch_stall) begin
            fetch_valid <= accept;
            if (accept) begin
              fetch_fault <= {fetch_oor, fetch_mis};
              fetch_instr <= (fetch_mis || fetch_oor) ? NOP_WORD : mem[fetch_idx];
            end
          end
        end
        S_PROG: fetch_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronously-read instruction memory that replaces the fixed combinational program ROM of the RV32 core.
- Supports configurable depth and width, a 1-cycle registered fetch with stall hold, and alignment and range fault reporting.
- Includes a runtime programming port so a loader can write programs without resynthesis.
- Includes an automatic clear-to-NOP sweep after reset.

Parameters:
- ADDR_W, 32: byte-address width of fetch_addr and prog_addr.
- DATA_W, 32: instruction word width.
- DEPTH, 256: number of words. Power of two, at least 4.
- NOP_WORD, 32'h00000013: word returned on faults and written by the clear sweep (addi x0,x0,0).
- CLEAR_ON_RESET, 1: 1 runs the clear sweep after reset; 0 goes straight to RUN with array contents untouched.

Ports:
- clk, in, 1: single clock. All logic on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- fetch_req, in, 1: fetch request.
- fetch_addr, in, ADDR_W: byte address of the instruction.
- fetch_stall, in, 1: core stall. Holds the output registers.
- fetch_ready, out, 1: high in RUN state only.
- fetch_valid, out, 1: fetch_instr holds the result of an accepted request.
- fetch_instr, out, DATA_W: fetched word.
- fetch_fault, out, 2: bit0 = misaligned (fetch_addr[1:0]≠0); bit1 = out of range (fetch_addr>>2 ≥ DEPTH).
- prog_en, in, 1: request programming mode.
- prog_we, in, 1: write strobe, valid in PROG.
- prog_addr, in, ADDR_W: byte address to write.
- prog_data, in, DATA_W: word to write.
- prog_err, out, 1: one-cycle pulse on a rejected write.
- busy, out, 1: high in CLEAR and PROG.

Behaviour:
- Reset values, while rst_n=0 at a clock edge: fetch_valid=0, fetch_instr=NOP_WORD, fetch_fault=0, prog_err=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Clear counter = 0.
  - The array itself is not reset.
- States:
  - CLEAR:
    - Each cycle writes NOP_WORD to mem[cnt] and increments cnt.
    - After the write of index DEPTH-1, moves to RUN, so CLEAR lasts exactly DEPTH cycles.
    - prog_en and fetch_req are ignored. busy=1, fetch_ready=0.
  - RUN:
    - If prog_en=1 and fetch_stall=0, moves to PROG next cycle. A fetch_req in that same cycle is not accepted.
    - If prog_en=1 and fetch_stall=1, stays in RUN until the stall drops.
  - PROG:
    - prog_en=0 returns to RUN next cycle.
    - fetch_valid forced to 0 on entry. fetch_req is ignored.
- Fetch acceptance: a request is accepted when state=RUN, fetch_req=1, fetch_stall=0, and no PROG transition is pending. One cycle later:
  - fetch_valid=1.
  - fetch_instr = mem[fetch_addr[log2(DEPTH)+1:2]], or NOP_WORD if any fault bit is set.
  - fetch_fault is registered alongside fetch_instr. Both fault bits may be set together.
- RUN with fetch_req=0 and fetch_stall=0: fetch_valid=0 next cycle. fetch_instr and fetch_fault keep their values.
- fetch_stall=1: fetch_valid, fetch_instr and fetch_fault all hold. A new request is not accepted. Back-to-back requests without stall give one result per cycle.
- Programming, in PROG with prog_we=1:
  - If prog_addr is aligned and in range, mem[prog_addr>>2] <= prog_data. The write is visible to a fetch accepted in any cycle after the write edge.
  - Otherwise nothing is written and prog_err pulses 1 in the next cycle.
  - prog_we outside PROG is ignored with no prog_err.
- Address decode uses only fetch_addr[log2(DEPTH)+1:2] for indexing. All higher bits count toward the range check, so there is no aliasing or wrap-around.
- Reset mid-CLEAR or mid-PROG: state restarts per the reset rule. Words already written keep their new values; a partial clear is restarted from index 0.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=256 -> busy=1 for exactly 256 cycles, then fetch_ready=1. Fetch of 0x40 returns 0x00000013 with fault=0.
- Program 0x00100293 at 0x38 and 0x0FF00603 at 0x3C, leave PROG, fetch 0x38 then 0x3C back-to-back -> valid on consecutive cycles with those words in order, 1-cycle latency.
- Fetch 0x3C then assert fetch_stall for 3 cycles while fetch_addr changes to 0x40 -> fetch_instr holds 0x0FF00603 and valid stays 1. 0x40 is accepted only after the stall drops.
- Fetch 0x42 -> fault=01 with NOP. Fetch 0x400 (DEPTH=256) -> fault=10 with NOP. Fetch 0x402 -> fault=11.
- In PROG, write to 0x401 and to 0x800 -> prog_err pulses once each. A later fetch of 0x000 shows the array unchanged.
- Assert rst_n=0 for one cycle at CLEAR index 100 -> sweep restarts at 0 and busy lasts 256 more cycles. prog_en asserted during the stalled RUN state enters PROG only after the stall is released.
